// File: rtl/ttl_7400_share_arbiter.sv
// Round-robin sequencer that time-shares one quad 2-input NAND package among
// four clocked requesters: latch operands, wait for the gates to settle, capture Y.
module ttl_7400_share_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        CLR_n,
  input  logic [3:0]  REQ,
  input  logic [15:0] OPA,
  input  logic [15:0] OPB,
  output logic [3:0]  GNT,
  output logic [3:0]  DONE,
  output logic [3:0]  RESULT,
  output logic        BUSY,
  output logic [3:0]  GA,
  output logic [3:0]  GB,
  input  logic [3:0]  GY
);

  localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CW    = $clog2(S_EFF + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_gnt;
  logic [3:0]      r_done;
  logic [3:0]      r_result;
  logic [3:0]      r_ga;
  logic [3:0]      r_gb;
  logic            r_busy;
  logic [1:0]      r_win;
  logic [1:0]      w_win_idx;
  logic            w_win_valid;
  logic [1:0]      w_scan_idx;

  // Scan from the farthest offset down so the closest pending request to r_ptr wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = r_ptr;
    w_scan_idx  = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_scan_idx = r_ptr + 2'(i);
      if (REQ[w_scan_idx]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_win_valid) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      r_ptr    <= 2'd0;
      r_cnt    <= '0;
      r_gnt    <= 4'd0;
      r_done   <= 4'd0;
      r_result <= 4'd0;
      r_ga     <= 4'd0;
      r_gb     <= 4'd0;
      r_busy   <= 1'b0;
      r_win    <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_gnt  <= 4'b0001 << w_win_idx;
            r_ga   <= OPA[{w_win_idx, 2'b00} +: 4];
            r_gb   <= OPB[{w_win_idx, 2'b00} +: 4];
            r_busy <= 1'b1;
            r_cnt  <= CW'(S_EFF);
            r_win  <= w_win_idx;
          end
        end
        ST_SETTLE: begin
          // GA/GB have now been stable for S_EFF full cycles; sample the package.
          if (r_cnt == CW'(1)) begin
            r_result <= GY;
            r_done   <= r_gnt;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          r_done <= 4'd0;
          r_gnt  <= 4'd0;
          r_ga   <= 4'd0;
          r_gb   <= 4'd0;
          r_busy <= 1'b0;
          r_ptr  <= r_win + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign DONE   = r_done;
  assign RESULT = r_result;
  assign BUSY   = r_busy;
  assign GA     = r_ga;
  assign GB     = r_gb;

endmodule

// File: tb/tb_ttl_7400_share_arbiter.sv
// Bench for ttl_7400_share_arbiter: three instances (settle 2, 4, 0) each driving
// a delayed NAND gate model, checked against a round-robin reference model.
module tb_ttl_7400_share_arbiter;

  logic        clk;
  logic        clr_n;
  logic [3:0]  req;
  logic [15:0] opa;
  logic [15:0] opb;
  int          sel;

  logic [3:0] req_i  [3];
  logic [3:0] gnt_o  [3];
  logic [3:0] done_o [3];
  logic [3:0] res_o  [3];
  logic       busy_o [3];
  logic [3:0] ga_o   [3];
  logic [3:0] gb_o   [3];
  logic [3:0] gy_i   [3];

  int n_tests;
  int n_fail;
  int ptr_m    [3];
  logic [3:0] last_res [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: 15 ns for the multi-cycle instances, 5 ns for the one-cycle one.
  assign #15 gy_i[0] = ~(ga_o[0] & gb_o[0]);
  assign #15 gy_i[1] = ~(ga_o[1] & gb_o[1]);
  assign #5  gy_i[2] = ~(ga_o[2] & gb_o[2]);

  always_comb begin
    for (int k = 0; k < 3; k++) req_i[k] = (sel == k) ? req : 4'b0000;
  end

  ttl_7400_share_arbiter #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .CLK(clk), .CLR_n(clr_n), .REQ(req_i[0]), .OPA(opa), .OPB(opb),
    .GNT(gnt_o[0]), .DONE(done_o[0]), .RESULT(res_o[0]), .BUSY(busy_o[0]),
    .GA(ga_o[0]), .GB(gb_o[0]), .GY(gy_i[0])
  );

  ttl_7400_share_arbiter #(.SETTLE_CYCLES(4)) u_dut_s4 (
    .CLK(clk), .CLR_n(clr_n), .REQ(req_i[1]), .OPA(opa), .OPB(opb),
    .GNT(gnt_o[1]), .DONE(done_o[1]), .RESULT(res_o[1]), .BUSY(busy_o[1]),
    .GA(ga_o[1]), .GB(gb_o[1]), .GY(gy_i[1])
  );

  ttl_7400_share_arbiter #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .CLK(clk), .CLR_n(clr_n), .REQ(req_i[2]), .OPA(opa), .OPB(opb),
    .GNT(gnt_o[2]), .DONE(done_o[2]), .RESULT(res_o[2]), .BUSY(busy_o[2]),
    .GA(ga_o[2]), .GB(gb_o[2]), .GY(gy_i[2])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester at or after the pointer, modulo 4.
  function automatic int pick_winner(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk({tag, "_gnt"},  {12'd0, gnt_o[sel]},  16'd0);
      chk({tag, "_busy"}, {15'd0, busy_o[sel]}, 16'd0);
      chk({tag, "_done"}, {12'd0, done_o[sel]}, 16'd0);
      chk({tag, "_res"},  {12'd0, res_o[sel]},  {12'd0, last_res[sel]});
    end
  endtask

  // One full operation on instance sel; REQ/operands must be set at the preceding negedge
  // while the instance is idle. With mutate, operands change and REQ drops mid-settle.
  task automatic run_op(input int s_param, input bit mutate);
    int s_eff;
    int w;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] oh;
    s_eff = (s_param < 1) ? 1 : s_param;
    w = pick_winner(req, ptr_m[sel]);
    if (w < 0) begin
      chk("run_op_no_request", 16'd0, 16'd1);
      return;
    end
    a  = opa[4*w +: 4];
    b  = opb[4*w +: 4];
    oh = 4'b0001 << w;
    @(negedge clk);
    chk("grant_gnt",  {12'd0, gnt_o[sel]},  {12'd0, oh});
    chk("grant_ga",   {12'd0, ga_o[sel]},   {12'd0, a});
    chk("grant_gb",   {12'd0, gb_o[sel]},   {12'd0, b});
    chk("grant_busy", {15'd0, busy_o[sel]}, 16'd1);
    chk("grant_done", {12'd0, done_o[sel]}, 16'd0);
    if (mutate) begin
      opa = 16'($urandom);
      opb = 16'($urandom);
      req = 4'b0000;
    end
    for (int j = 1; j < s_eff; j++) begin
      @(negedge clk);
      chk("settle_done", {12'd0, done_o[sel]}, 16'd0);
      chk("settle_gnt",  {12'd0, gnt_o[sel]},  {12'd0, oh});
      chk("settle_ga",   {12'd0, ga_o[sel]},   {12'd0, a});
      chk("settle_res",  {12'd0, res_o[sel]},  {12'd0, last_res[sel]});
    end
    @(negedge clk);
    last_res[sel] = ~(a & b);
    chk("done_pulse",  {12'd0, done_o[sel]}, {12'd0, oh});
    chk("done_result", {12'd0, res_o[sel]},  {12'd0, last_res[sel]});
    chk("done_busy",   {15'd0, busy_o[sel]}, 16'd1);
    @(negedge clk);
    chk("end_done", {12'd0, done_o[sel]}, 16'd0);
    chk("end_gnt",  {12'd0, gnt_o[sel]},  16'd0);
    chk("end_ga",   {12'd0, ga_o[sel]},   16'd0);
    chk("end_gb",   {12'd0, gb_o[sel]},   16'd0);
    chk("end_busy", {15'd0, busy_o[sel]}, 16'd0);
    chk("end_res",  {12'd0, res_o[sel]},  {12'd0, last_res[sel]});
    ptr_m[sel] = (w + 1) % 4;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    sel     = 0;
    clr_n   = 1'b0;
    req     = 4'b0000;
    opa     = 16'd0;
    opb     = 16'd0;
    for (int k = 0; k < 3; k++) begin
      ptr_m[k]    = 0;
      last_res[k] = 4'd0;
    end

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",  {12'd0, gnt_o[0]},  16'd0);
    chk("rst_done", {12'd0, done_o[0]}, 16'd0);
    chk("rst_res",  {12'd0, res_o[0]},  16'd0);
    chk("rst_busy", {15'd0, busy_o[0]}, 16'd0);
    chk("rst_ga",   {12'd0, ga_o[0]},   16'd0);
    chk("rst_gb",   {12'd0, gb_o[0]},   16'd0);
    clr_n = 1'b1;

    // Single request, known operands
    req = 4'b0001;
    opa = 16'h000C;
    opb = 16'h000A;
    run_op(2, 1'b0);
    chk("t1_result_const", {12'd0, res_o[0]}, 16'h0007);
    req = 4'b0000;
    check_idle("idle_after_t1", 3);

    // All four requesting, back to back
    req = 4'b1111;
    opa = 16'($urandom);
    opb = 16'($urandom);
    for (int n = 0; n < 5; n++) run_op(2, 1'b0);

    // Two requesters alternating
    req = 4'b0101;
    for (int n = 0; n < 4; n++) begin
      opa = 16'($urandom);
      opb = 16'($urandom);
      run_op(2, 1'b0);
    end

    // Random request patterns and operands
    for (int n = 0; n < 16; n++) begin
      req = 4'($urandom_range(1, 15));
      opa = 16'($urandom);
      opb = 16'($urandom);
      run_op(2, 1'b0);
    end

    // Operands changed and REQ dropped during settle
    req = 4'b0010;
    opa = 16'($urandom);
    opb = 16'($urandom);
    run_op(2, 1'b1);
    check_idle("idle_after_t4", 2);

    // Asynchronous reset mid-settle
    req = 4'b0100;
    opa = 16'($urandom);
    opb = 16'($urandom);
    @(posedge clk);
    #3;
    req   = 4'b0000;
    clr_n = 1'b0;
    #1;
    chk("arst_gnt",  {12'd0, gnt_o[0]},  16'd0);
    chk("arst_ga",   {12'd0, ga_o[0]},   16'd0);
    chk("arst_gb",   {12'd0, gb_o[0]},   16'd0);
    chk("arst_busy", {15'd0, busy_o[0]}, 16'd0);
    chk("arst_res",  {12'd0, res_o[0]},  16'd0);
    for (int k = 0; k < 3; k++) begin
      ptr_m[k]    = 0;
      last_res[k] = 4'd0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("arst_no_done", {12'd0, done_o[0]}, 16'd0);
    clr_n = 1'b1;
    check_idle("idle_after_arst", 2);
    req = 4'b1000;
    opa = 16'($urandom);
    opb = 16'($urandom);
    run_op(2, 1'b0);
    chk("arst_ptr_wrap", 16'(ptr_m[0]), 16'd0);
    req = 4'b1111;
    run_op(2, 1'b0);
    chk("arst_next_ptr", 16'(ptr_m[0]), 16'd1);

    // Longer settle instance
    req = 4'b0000;
    sel = 1;
    for (int n = 0; n < 4; n++) begin
      req = 4'($urandom_range(1, 15));
      opa = 16'($urandom);
      opb = 16'($urandom);
      run_op(4, 1'b0);
    end

    // Settle of 0 behaves as 1
    req = 4'b0000;
    sel = 2;
    for (int n = 0; n < 4; n++) begin
      req = 4'($urandom_range(1, 15));
      opa = 16'($urandom);
      opb = 16'($urandom);
      run_op(0, 1'b0);
    end
    req = 4'b0000;
    check_idle("idle_s0", 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
